// File: rtl/trigger_sched.sv
// Frame-trigger scheduler: decimates IMU strobes into frames and drives centre-aligned camera triggers.
// Optional feature macro TRIG_TIMESTAMP_EN adds ts_usec, a free-running usec stamp latched at frame start.

module trigger_sched #(
  parameter int unsigned NUM_CAM      = 2,
  parameter int unsigned CLK_PER_USEC = 125,
  parameter int unsigned HOLDOFF_USEC = 100
) (
  input  logic                  c,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  imu_sync,
  input  logic                  cfg_wr,
  input  logic [7:0]            cfg_decim,
  input  logic [16*NUM_CAM-1:0] cfg_exp,
  output logic [NUM_CAM-1:0]    trig,
  output logic                  frame_start,
  output logic [31:0]           frame_cnt,
  output logic [7:0]            overrun_cnt,
  output logic                  busy
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]           ts_usec
`endif
);

  localparam int unsigned PRE_W = (CLK_PER_USEC > 1) ? $clog2(CLK_PER_USEC) : 1;
  localparam int unsigned EXP_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                        state, state_d;
  logic [PRE_W-1:0]              pre, pre_d;
  logic [EXP_W-1:0]              t, t_d;
  logic [NUM_CAM-1:0]            trig_d;

  logic [7:0]                    imu_cnt;
  logic [8:0]                    imu_inc;
  logic [7:0]                    pend_decim, act_decim, src_decim, decim_eff;
  logic [NUM_CAM-1:0][EXP_W-1:0] pend_exp, act_exp, act_off, src_exp, src_off;
  logic [EXP_W-1:0]              exp_max, src_max;
  logic                          pend_v, req_hold;
  logic                          usec_tick_c, frame_req_c, req_c, apply_c, start_c;

  // Config source for an apply: a write this cycle bypasses the shadow so it lands immediately in IDLE
  always_comb begin
    src_decim = cfg_wr ? cfg_decim : pend_decim;
    src_exp   = cfg_wr ? cfg_exp : pend_exp;
    src_max   = '0;
    src_off   = '0;
    for (int i = 0; i < NUM_CAM; i++) begin
      if (src_exp[i] > src_max) src_max = src_exp[i];
    end
    for (int i = 0; i < NUM_CAM; i++) begin
      src_off[i] = (src_max - src_exp[i]) >> 1;
    end
  end

  assign decim_eff   = (act_decim == 8'd0) ? 8'd1 : act_decim;
  assign imu_inc     = {1'b0, imu_cnt} + 9'd1;
  assign frame_req_c = imu_sync && (imu_inc >= {1'b0, decim_eff});
  assign req_c       = frame_req_c || req_hold;
  assign apply_c     = (state == IDLE) && (cfg_wr || pend_v);
  assign start_c     = (state == IDLE) && req_c && en && !apply_c;
  assign usec_tick_c = (pre == PRE_W'(CLK_PER_USEC - 1));

  // Next-state, usec timebase and trigger windows
  always_comb begin
    state_d = state;
    pre_d   = usec_tick_c ? '0 : pre + PRE_W'(1);
    t_d     = usec_tick_c ? t + EXP_W'(1) : t;
    trig_d  = '0;
    case (state)
      IDLE: begin
        pre_d = '0;
        t_d   = '0;
        if (start_c) state_d = RUN;
      end
      RUN: begin
        if ((exp_max == '0) || (usec_tick_c && ((t + EXP_W'(1)) == exp_max))) begin
          state_d = HOLDOFF;
          pre_d   = '0;
          t_d     = '0;
        end
      end
      HOLDOFF: begin
        if (usec_tick_c && (t == EXP_W'(HOLDOFF_USEC - 1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RUN) begin
      for (int i = 0; i < NUM_CAM; i++) begin
        trig_d[i] = (t_d >= act_off[i]) &&
                    ({1'b0, t_d} < ({1'b0, act_off[i]} + {1'b0, act_exp[i]}));
      end
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pre         <= '0;
      t           <= '0;
      trig        <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      pre         <= pre_d;
      t           <= t_d;
      trig        <= trig_d;
      frame_start <= start_c;
      busy        <= (state_d != IDLE);
    end
  end

  // Request decimation and host-visible counters
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      imu_cnt     <= '0;
      req_hold    <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (imu_sync) imu_cnt <= frame_req_c ? 8'd0 : imu_cnt + 8'd1;
      req_hold <= apply_c && req_c;
      if (start_c) frame_cnt <= frame_cnt + 32'd1;
      if (frame_req_c && (state != IDLE) && (overrun_cnt != 8'hff))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  // Shadow and active configuration; active only changes between frames
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      pend_v     <= 1'b0;
      pend_decim <= 8'd1;
      pend_exp   <= '0;
      act_decim  <= 8'd1;
      act_exp    <= '0;
      act_off    <= '0;
      exp_max    <= '0;
    end else begin
      if (cfg_wr) begin
        pend_decim <= cfg_decim;
        pend_exp   <= cfg_exp;
      end
      if (apply_c) begin
        pend_v    <= 1'b0;
        act_decim <= src_decim;
        act_exp   <= src_exp;
        act_off   <= src_off;
        exp_max   <= src_max;
      end else if (cfg_wr) begin
        pend_v <= 1'b1;
      end
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [PRE_W-1:0] ts_pre;
  logic [31:0]      ts_cnt;
  logic             ts_tick_c;

  assign ts_tick_c = (ts_pre == PRE_W'(CLK_PER_USEC - 1));

  // Free-running usec counter, never restarted by frames
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      ts_pre  <= '0;
      ts_cnt  <= '0;
      ts_usec <= '0;
    end else begin
      ts_pre <= ts_tick_c ? '0 : ts_pre + PRE_W'(1);
      if (ts_tick_c) ts_cnt <= ts_cnt + 32'd1;
      if (start_c) ts_usec <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_trigger_sched.sv
// Self-checking bench for trigger_sched: interval-based frame model plus directed literal pins.
// Runs with a short timebase so complete frames fit in a few thousand cycles.

module tb_trigger_sched;

  localparam int NCAM    = 2;
  localparam int CPU     = 3;
  localparam int HOLD_US = 4;
  localparam int HCYC    = CPU * HOLD_US;

  logic        c = 1'b0;
  logic        rst, en, imu_sync, cfg_wr;
  logic [7:0]  cfg_decim;
  logic [31:0] cfg_exp;
  logic [1:0]  trig;
  logic        frame_start, busy;
  logic [31:0] frame_cnt;
  logic [7:0]  overrun_cnt;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] ts_usec;
`endif

  trigger_sched #(
    .NUM_CAM(NCAM),
    .CLK_PER_USEC(CPU),
    .HOLDOFF_USEC(HOLD_US)
  ) dut (
    .c(c),
    .rst(rst),
    .en(en),
    .imu_sync(imu_sync),
    .cfg_wr(cfg_wr),
    .cfg_decim(cfg_decim),
    .cfg_exp(cfg_exp),
    .trig(trig),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt),
    .overrun_cnt(overrun_cnt),
`ifdef TRIG_TIMESTAMP_EN
    .ts_usec(ts_usec),
`endif
    .busy(busy)
  );

  always #5 c = ~c;

  int errors = 0;
  int checks = 0;
  int j = 0;

  // Reference model: frame is an interval [fs, fs+flen+HCYC) of busy cycles
  int          m_imu, m_decim, m_pdec;
  int          m_exp[NCAM];
  int          m_pexp[NCAM];
  bit          m_pv, m_hold;
  bit          fs_v;
  int          fs, flen;
  int          f_exp[NCAM];
  int          f_off[NCAM];
  logic [31:0] m_fcnt;
  int          m_ovr;
  logic [1:0]  e_trig;
  bit          e_fs, e_busy;

  function automatic bit in_frame(input int k);
    return fs_v && (k >= fs) && (k < fs + flen + HCYC);
  endfunction

  task automatic set_expect();
    int d;
    d      = j - fs;
    e_busy = in_frame(j);
    e_fs   = fs_v && (j == fs);
    for (int i = 0; i < NCAM; i++)
      e_trig[i] = fs_v && (d >= f_off[i] * CPU) && (d < (f_off[i] + f_exp[i]) * CPU);
  endtask

  task automatic model_reset();
    m_imu   = 0;
    m_decim = 1;
    m_pdec  = 1;
    for (int i = 0; i < NCAM; i++) begin
      m_exp[i]  = 0;
      m_pexp[i] = 0;
      f_exp[i]  = 0;
      f_off[i]  = 0;
    end
    m_pv   = 0;
    m_hold = 0;
    fs_v   = 0;
    fs     = 0;
    flen   = 0;
    m_fcnt = '0;
    m_ovr  = 0;
    set_expect();
  endtask

  task automatic model_step();
    bit idle, req, apply, reqe, start;
    int dec_eff, mx;
    idle    = !in_frame(j);
    dec_eff = (m_decim == 0) ? 1 : m_decim;
    req     = imu_sync && (m_imu + 1 >= dec_eff);
    if (imu_sync) m_imu = req ? 0 : m_imu + 1;
    apply = idle && (cfg_wr || m_pv);
    reqe  = req || m_hold;
    start = idle && reqe && en && !apply;
    if (req && !idle && m_ovr < 255) m_ovr++;
    m_hold = apply && reqe;
    if (apply) begin
      if (cfg_wr) begin
        m_decim = int'(cfg_decim);
        for (int i = 0; i < NCAM; i++) m_exp[i] = int'(cfg_exp[16*i +: 16]);
      end else begin
        m_decim = m_pdec;
        for (int i = 0; i < NCAM; i++) m_exp[i] = m_pexp[i];
      end
      m_pv = 0;
    end else if (cfg_wr) begin
      m_pdec = int'(cfg_decim);
      for (int i = 0; i < NCAM; i++) m_pexp[i] = int'(cfg_exp[16*i +: 16]);
      m_pv = 1;
    end
    if (start) begin
      mx = 0;
      for (int i = 0; i < NCAM; i++) if (m_exp[i] > mx) mx = m_exp[i];
      fs_v = 1;
      fs   = j + 1;
      flen = (mx == 0) ? 1 : mx * CPU;
      for (int i = 0; i < NCAM; i++) begin
        f_exp[i] = m_exp[i];
        f_off[i] = (mx - m_exp[i]) / 2;
      end
      m_fcnt = m_fcnt + 32'd1;
    end
    j++;
    set_expect();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, j, got, want);
    end
  endtask

  task automatic check_outputs();
    chk("trig", {30'd0, trig}, {30'd0, e_trig});
    chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    chk("frame_cnt", frame_cnt, m_fcnt);
    chk("overrun_cnt", {24'd0, overrun_cnt}, 32'(m_ovr));
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
  endtask

  task automatic tick(input bit s_imu, input bit s_cfg, input bit s_en,
                      input logic [7:0] dec, input logic [31:0] ex);
    imu_sync  = s_imu;
    cfg_wr    = s_cfg;
    en        = s_en;
    cfg_decim = dec;
    cfg_exp   = ex;
    model_step();
    @(negedge c);
    check_outputs();
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b1, 8'd0, 32'd0);
  endtask

  task automatic random_phase(input int n);
    bit en_r;
    en_r = 1'b1;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 199) == 0) en_r = !en_r;
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, en_r,
           8'($urandom_range(0, 3)),
           {16'($urandom_range(0, 10)), 16'($urandom_range(0, 10))});
    end
  endtask

  initial begin
    int fire, rise0, rise1, fsr, h0, h1, syncs;
    logic p0, p1;

    rst = 1'b1; en = 1'b0; imu_sync = 1'b0; cfg_wr = 1'b0;
    cfg_decim = 8'd0; cfg_exp = 32'd0;
    model_reset();
    repeat (2) @(negedge c);
    check_outputs();
    rst = 1'b0;

    // Decimation by 4, exposures {10,4}: camera 1 centred 3 usec in
    tick(1'b0, 1'b1, 1'b1, 8'd4, {16'd4, 16'd10});
    fire = -1; rise0 = -1; rise1 = -1; h0 = 0; h1 = 0; syncs = 0; p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (n % 20 == 19) begin
        syncs++;
        if (syncs == 4) fire = j;
      end
      tick(n % 20 == 19, 1'b0, 1'b1, 8'd0, 32'd0);
      if (trig[0] && !p0 && rise0 < 0) rise0 = j;
      if (trig[1] && !p1 && rise1 < 0) rise1 = j;
      h0 += int'(trig[0]);
      h1 += int'(trig[1]);
      p0 = trig[0];
      p1 = trig[1];
    end
    chk("A_trig0_latency", 32'(rise0 - fire), 32'd1);
    chk("A_trig1_offset", 32'(rise1 - rise0), 32'd9);
    chk("A_trig0_cycles", 32'(h0), 32'd90);
    chk("A_trig1_cycles", 32'(h1), 32'd36);
    chk("A_frame_cnt", frame_cnt, 32'd3);

    // Exposure rewritten mid-RUN: current frame keeps the old length
    tick(1'b0, 1'b1, 1'b1, 8'd1, {16'd20, 16'd20});
    h0 = 0;
    for (int n = 0; n < 80; n++) begin
      tick(n == 0, n == 25, 1'b1, 8'd1, {16'd5, 16'd5});
      h0 += int'(trig[0]);
    end
    chk("B_old_exposure", 32'(h0), 32'd60);
    h0 = 0;
    for (int n = 0; n < 40; n++) begin
      tick(n == 0, 1'b0, 1'b1, 8'd0, 32'd0);
      h0 += int'(trig[0]);
    end
    chk("B_new_exposure", 32'(h0), 32'd15);

    // Config write coincident with a firing strobe in IDLE
    fire = j;
    tick(1'b1, 1'b1, 1'b1, 8'd1, {16'd7, 16'd7});
    fsr = -1; h0 = 0;
    for (int n = 0; n < 40; n++) begin
      tick(1'b0, 1'b0, 1'b1, 8'd0, 32'd0);
      if (frame_start && fsr < 0) fsr = j;
      h0 += int'(trig[0]);
    end
    chk("C_start_delay", 32'(fsr - fire), 32'd2);
    chk("C_new_exposure", 32'(h0), 32'd21);

    random_phase(3000);
    quiet(80);

    // Continuous requests against a long frame saturate the overrun counter
    tick(1'b0, 1'b1, 1'b1, 8'd1, {16'd20, 16'd0});
    for (int n = 0; n < 450; n++) tick(1'b1, 1'b0, 1'b1, 8'd0, 32'd0);
    chk("D_overrun_sat", {24'd0, overrun_cnt}, 32'd255);
    quiet(80);

    // Reset in the middle of an exposure
    tick(1'b0, 1'b1, 1'b1, 8'd1, {16'd20, 16'd20});
    tick(1'b1, 1'b0, 1'b1, 8'd0, 32'd0);
    quiet(10);
    imu_sync = 1'b0;
    cfg_wr   = 1'b0;
    rst      = 1'b1;
    #1;
    chk("E_rst_trig", {30'd0, trig}, 32'd0);
    chk("E_rst_busy", {31'd0, busy}, 32'd0);
    chk("E_rst_frame_cnt", frame_cnt, 32'd0);
    model_reset();
    @(negedge c);
    j++;
    set_expect();
    check_outputs();
    rst = 1'b0;
    h0 = 0;
    tick(1'b1, 1'b0, 1'b1, 8'd0, 32'd0);
    for (int n = 0; n < 30; n++) begin
      tick(1'b0, 1'b0, 1'b1, 8'd0, 32'd0);
      h0 += int'(trig[0]) + int'(trig[1]);
    end
    chk("E_no_trig_after_rst", 32'(h0), 32'd0);
    chk("E_frame_cnt_after_rst", frame_cnt, 32'd1);

    random_phase(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
